// File: rtl/eva_axi_rd_slave.sv
// AXI read-only slave over an internal word memory: in-order AR queue, latency stage and burst engine.
// Define EVA_AXI_RD_ERR_EN to answer unsupported bursts and out-of-range beats with SLVERR.
module eva_axi_rd_slave #(
    parameter int DW     = 128,
    parameter int IDW    = 4,
    parameter int MEM_AW = 10,
    parameter int QDEPTH = 4,
    parameter int RD_LAT = 2
) (
    input  logic              aclk,
    input  logic              arest_n,
    input  logic              arvalid,
    output logic              arready,
    input  logic [IDW-1:0]    arid,
    input  logic [31:0]       araddr,
    input  logic [5:0]        arlen,
    input  logic [2:0]        arsize,
    input  logic [1:0]        arburst,
    output logic              rvalid,
    input  logic              rready,
    output logic [IDW-1:0]    rid,
    output logic [DW-1:0]     rdata,
    output logic              rlast,
    output logic [1:0]        rresp,
    input  logic              mem_we,
    input  logic [MEM_AW-1:0] mem_waddr,
    input  logic [DW-1:0]     mem_wdata
);

    localparam int OFFB  = $clog2(DW / 8);
    localparam int PW    = $clog2(QDEPTH);
    localparam int OW    = PW + 1;
    localparam int DEPTH = 1 << MEM_AW;

    localparam logic [OW-1:0]     OCC_FULL = OW'(QDEPTH);
    localparam logic [OW-1:0]     OCC_ONE  = {{(OW-1){1'b0}}, 1'b1};
    localparam logic [PW-1:0]     PTR_ONE  = {{(PW-1){1'b0}}, 1'b1};
    localparam logic [MEM_AW-1:0] IDX_ONE  = {{(MEM_AW-1){1'b0}}, 1'b1};
    localparam logic [MEM_AW-1:0] IDX_MAX  = {MEM_AW{1'b1}};
    localparam logic [3:0]        LAT_END  = 4'((RD_LAT > 0) ? (RD_LAT - 1) : 0);
    localparam logic [2:0]        SIZE_NAT = 3'(OFFB);

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_LAT  = 2'b01,
        ST_DATA = 2'b10
    } state_t;

    function automatic logic f_burst_err(input logic [1:0] burst, input logic [2:0] size);
        return burst[1] || (size != SIZE_NAT);
    endfunction

    // Storage
    logic [DW-1:0]     r_mem     [DEPTH];
    logic [IDW-1:0]    r_q_id    [QDEPTH];
    logic [MEM_AW-1:0] r_q_idx   [QDEPTH];
    logic [5:0]        r_q_len   [QDEPTH];
    logic [1:0]        r_q_burst [QDEPTH];
    logic              r_q_err   [QDEPTH];
    logic              r_q_hi    [QDEPTH];

    logic [PW-1:0]     r_wptr;
    logic [PW-1:0]     r_rptr;
    logic [OW-1:0]     r_cnt;
    logic [OW-1:0]     r_occ;
    logic              r_arready;

    state_t            r_state;
    logic [3:0]        r_lat_cnt;
    logic [IDW-1:0]    r_id;
    logic [MEM_AW-1:0] r_idx;
    logic [5:0]        r_left;
    logic [1:0]        r_burst;
    logic              r_err;
    logic              r_ovf;
    logic              r_rvalid;
    logic              r_rlast;
    logic [1:0]        r_rresp;
    logic [DW-1:0]     r_rdata;
    logic [IDW-1:0]    r_rid;

    logic [31:0]       w_ar_widx;
    logic [MEM_AW-1:0] w_ar_idx;
    logic              w_ar_hi;
    logic              w_ar_err;
    logic [IDW-1:0]    w_h_id;
    logic [MEM_AW-1:0] w_h_idx;
    logic [5:0]        w_h_len;
    logic [1:0]        w_h_burst;
    logic              w_h_err;
    logic              w_h_hi;

    logic              w_push;
    logic              w_pop;
    logic              w_hs;
    logic              w_rel;
    logic              w_fixed;
    logic [MEM_AW-1:0] w_adv_idx;
    logic              w_adv_ovf;
    logic              w_load;
    logic [MEM_AW-1:0] w_raddr;
    logic              w_rd_err;
    logic              w_rd_ovf;
    logic              w_rd_bad;
    logic [5:0]        w_ld_left;
    logic [IDW-1:0]    w_ld_id;
    logic [OW-1:0]     w_occ_nxt;

    // hi flags an AR whose start index already lies beyond the memory
    assign w_ar_widx = araddr >> OFFB;
    assign w_ar_idx  = w_ar_widx[MEM_AW-1:0];
    assign w_ar_hi   = |(w_ar_widx >> MEM_AW);
    assign w_ar_err  = f_burst_err(arburst, arsize);

    assign w_h_id    = r_q_id[r_rptr];
    assign w_h_idx   = r_q_idx[r_rptr];
    assign w_h_len   = r_q_len[r_rptr];
    assign w_h_burst = r_q_burst[r_rptr];
    assign w_h_err   = r_q_err[r_rptr];
    assign w_h_hi    = r_q_hi[r_rptr];

`ifdef EVA_AXI_RD_ERR_EN
    assign w_rd_bad = w_rd_err || w_rd_ovf;
`else
    logic w_unused;
    assign w_rd_bad = 1'b0;
    assign w_unused = w_rd_err ^ w_rd_ovf;
`endif

    // Handshakes, next-beat index and the address/attributes of the beat about to be loaded
    always_comb begin
        w_push    = arvalid && r_arready;
        w_pop     = (r_state == ST_IDLE) && (r_cnt != {OW{1'b0}});
        w_hs      = r_rvalid && rready;
        w_rel     = w_hs && r_rlast;
        w_fixed   = (r_burst == 2'b00);
        w_adv_idx = w_fixed ? r_idx : (r_idx + IDX_ONE);
        w_adv_ovf = r_ovf || (!w_fixed && (r_idx == IDX_MAX));
        w_raddr   = r_idx;
        w_rd_err  = r_err;
        w_rd_ovf  = r_ovf;
        w_ld_left = r_left;
        w_ld_id   = r_id;
        w_load    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_raddr   = w_h_idx;
                w_rd_err  = w_h_err;
                w_rd_ovf  = w_h_hi;
                w_ld_left = w_h_len;
                w_ld_id   = w_h_id;
                w_load    = w_pop && (RD_LAT == 0);
            end
            ST_LAT: begin
                w_load = (r_lat_cnt == LAT_END);
            end
            ST_DATA: begin
                w_raddr   = w_adv_idx;
                w_rd_ovf  = w_adv_ovf;
                w_ld_left = r_left - 6'd1;
                w_load    = w_hs && !r_rlast;
            end
            default: begin
                w_load = 1'b0;
            end
        endcase
    end

    // Occupancy counts a burst from acceptance until its last beat is taken
    always_comb begin
        case ({w_push, w_rel})
            2'b10:   w_occ_nxt = r_occ + OCC_ONE;
            2'b01:   w_occ_nxt = r_occ - OCC_ONE;
            default: w_occ_nxt = r_occ;
        endcase
    end

    // Preload write port; memory contents survive reset
    always_ff @(posedge aclk) begin
        if (mem_we) begin
            r_mem[mem_waddr] <= mem_wdata;
        end
    end

    // AR queue payload
    always_ff @(posedge aclk) begin
        if (w_push) begin
            r_q_id[r_wptr]    <= arid;
            r_q_idx[r_wptr]   <= w_ar_idx;
            r_q_len[r_wptr]   <= arlen;
            r_q_burst[r_wptr] <= arburst;
            r_q_err[r_wptr]   <= w_ar_err;
            r_q_hi[r_wptr]    <= w_ar_hi;
        end
    end

    // AR queue pointers, fill level and registered arready
    always_ff @(posedge aclk or negedge arest_n) begin
        if (!arest_n) begin
            r_wptr    <= {PW{1'b0}};
            r_rptr    <= {PW{1'b0}};
            r_cnt     <= {OW{1'b0}};
            r_occ     <= {OW{1'b0}};
            r_arready <= 1'b0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + PTR_ONE;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + PTR_ONE;
            end
            case ({w_push, w_pop})
                2'b10:   r_cnt <= r_cnt + OCC_ONE;
                2'b01:   r_cnt <= r_cnt - OCC_ONE;
                default: r_cnt <= r_cnt;
            endcase
            r_occ     <= w_occ_nxt;
            r_arready <= (w_occ_nxt != OCC_FULL);
        end
    end

    // Read engine FSM with registered beat outputs; memory read doubles as the output register
    always_ff @(posedge aclk or negedge arest_n) begin
        if (!arest_n) begin
            r_state   <= ST_IDLE;
            r_lat_cnt <= 4'd0;
            r_id      <= {IDW{1'b0}};
            r_idx     <= {MEM_AW{1'b0}};
            r_left    <= 6'd0;
            r_burst   <= 2'b00;
            r_err     <= 1'b0;
            r_ovf     <= 1'b0;
            r_rvalid  <= 1'b0;
            r_rlast   <= 1'b0;
            r_rresp   <= 2'b00;
            r_rdata   <= {DW{1'b0}};
            r_rid     <= {IDW{1'b0}};
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_pop) begin
                        r_id      <= w_h_id;
                        r_idx     <= w_h_idx;
                        r_left    <= w_h_len;
                        r_burst   <= w_h_burst;
                        r_err     <= w_h_err;
                        r_ovf     <= w_h_hi;
                        r_lat_cnt <= 4'd0;
                        r_state   <= (RD_LAT == 0) ? ST_DATA : ST_LAT;
                    end
                end
                ST_LAT: begin
                    if (r_lat_cnt == LAT_END) begin
                        r_state <= ST_DATA;
                    end else begin
                        r_lat_cnt <= r_lat_cnt + 4'd1;
                    end
                end
                ST_DATA: begin
                    if (w_hs) begin
                        if (r_rlast) begin
                            r_state <= ST_IDLE;
                        end else begin
                            r_idx  <= w_adv_idx;
                            r_ovf  <= w_adv_ovf;
                            r_left <= r_left - 6'd1;
                        end
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase

            if (w_load) begin
                r_rvalid <= 1'b1;
                r_rid    <= w_ld_id;
                r_rlast  <= (w_ld_left == 6'd0);
                r_rresp  <= w_rd_bad ? 2'b10 : 2'b00;
                r_rdata  <= w_rd_bad ? {DW{1'b0}} : r_mem[w_raddr];
            end else if (w_rel) begin
                r_rvalid <= 1'b0;
                r_rlast  <= 1'b0;
                r_rresp  <= 2'b00;
            end
        end
    end

    assign arready = r_arready;
    assign rvalid  = r_rvalid;
    assign rid     = r_rid;
    assign rdata   = r_rdata;
    assign rlast   = r_rlast;
    assign rresp   = r_rresp;

endmodule
